keccak_sponge_ctrl: RTL and testbench
=====================================

Name: keccak_sponge_ctrl

Overview:
Parametrised control unit for the Keccak sponge datapath, covering SHA3/SHAKE at any rate. It buffers a message of up to DEPTH rate blocks, then sequences absorb and permutation rounds over the shared state register. It then produces a requested number of output blocks through a ready/valid squeeze handshake. It drives the block-buffer addresses, the state-input select and the round index used by the round-constant lookup.

Parameters:
BLOCK_W, 1088, rate in bits; one buffer entry (1088 = SHAKE256, 1344 = SHAKE128)
DEPTH, 8, message buffer depth in blocks (>=2)
ROUNDS, 24, permutation rounds per block
LEN_W, 11, width of in_len; must satisfy 2**LEN_W > BLOCK_W
SQ_W, 8, width of the squeeze-block count

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a new hash; honoured only in IDLE
sq_blocks  in  SQ_W  number of output blocks; sampled with start; 0 is treated as 1
in_valid  in  1  message block valid
in_last  in  1  current block is the final block
in_len  in  LEN_W  valid bits in the final block (0..BLOCK_W)
in_ready  out  1  buffer accepts a block this cycle
wr_addr  out  clog2(DEPTH)  buffer write address
wren  out  1  buffer write enable (= in_valid & in_ready)
rd_addr  out  clog2(DEPTH)  buffer read address for absorb
last_len  out  LEN_W  latched in_len of the final block, used by the pad logic
last_sel  out  1  the block being absorbed is the final one; pad is applied
state_sel  out  2  0 = permute, 1 = absorb (state XOR block), 2 = hold
round_idx  out  clog2(ROUNDS)  current round number
aclr  out  1  clears the state register
out_valid  out  1  state holds a valid output block
out_ready  in  1  downstream consumed the block
busy  out  1  high in every state except IDLE
full  out  1  buffer holds DEPTH blocks
err  out  1  sticky error; cleared by reset or by the next accepted start

Behaviour:
- Reset values (asynchronous): state IDLE; all outputs 0 except state_sel = 2. Counters and latched sq_blocks/last_len are 0.
- States: IDLE, FILL, ABSORB, PERMUTE, SQUEEZE.
- IDLE:
  - start -> FILL. sq_blocks is latched and err is cleared.
  - aclr is high for exactly the first FILL cycle.
- FILL:
  - in_ready = ~full.
  - Each accepted block writes to wr_addr; wr_addr and block_cnt then increment.
  - Accepted block with in_last: last_len <= in_len; go to ABSORB next cycle. rd_addr = 0.
  - in_len > BLOCK_W on the last block: err = 1, return to IDLE, nothing absorbed.
  - block_cnt reaches DEPTH without in_last: full = 1, in_ready = 0, err = 1, return to IDLE on the next cycle.
  - in_len = 0 on the last block is legal; the datapath absorbs a pure pad block.
- ABSORB (1 cycle):
  - state_sel = 1, rd_addr = current block, last_sel = (rd_addr == block_cnt-1).
  - Next state PERMUTE with round_idx = 0.
- PERMUTE (ROUNDS cycles):
  - state_sel = 0; round_idx counts 0..ROUNDS-1.
  - After round ROUNDS-1: if blocks remain, rd_addr increments and the FSM goes to ABSORB; otherwise it goes to SQUEEZE.
  - While squeezing, the same PERMUTE sequence is reused and returns to SQUEEZE.
- SQUEEZE:
  - out_valid = 1, state_sel = 2; hold while out_ready = 0.
  - On handshake: if fewer than sq_blocks have been delivered, go to PERMUTE; otherwise go to IDLE (busy drops the next cycle).
- Latency:
  - Final block accepted at cycle F gives out_valid at F + 1 + n*(ROUNDS+1) for n blocks.
  - A squeeze handshake at cycle S gives the next out_valid at S + ROUNDS + 1.
- start outside IDLE is ignored.
- Reset mid-operation returns immediately to IDLE with reset values. Buffer contents are don't-care.

Optional Feature:
SPONGE_ABORT_EN:
- Defined: adds input port abort (1 bit). abort high in any non-IDLE state returns the FSM to IDLE on the next clock.
  - out_valid and in_ready drop that cycle; aclr pulses 1 cycle; err is unchanged.
  - abort has priority over every transition, including a simultaneous out_valid/out_ready handshake, which is not counted.
- Not defined: no abort port; the FSM runs only to completion or reset.

Test Plan:
- Defaults; start with sq_blocks = 1; one block, in_last = 1, in_len = 0 accepted at cycle F -> rd_addr = 0, last_sel = 1, out_valid at F+26; after out_ready, busy = 0 at F+28.
- 3 blocks, last in_len = 500, sq_blocks = 1 -> ABSORB at rd_addr 0, 1, 2 (last_sel only on 2), last_len = 500, out_valid at F+76.
- 1 block, sq_blocks = 3, out_ready held low 5 cycles on each block -> exactly 3 out_valid handshakes, each followed by 24 state_sel = 0 cycles with round_idx 0..23.
- 8 blocks without in_last -> full = 1 and in_ready = 0 after the 8th write, err = 1, FSM in IDLE; next start clears err.
- Last block with in_len = 1089 -> err = 1, no ABSORB cycle; reset asserted mid-PERMUTE -> all outputs at reset values immediately.
- With SPONGE_ABORT_EN: abort during round 10 of the 2nd block -> IDLE next cycle, aclr = 1 for 1 cycle, out_valid never asserted.

Source files
------------

// File: rtl/keccak_sponge_ctrl_if.sv
// Message-in and squeeze-out handshakes between the Keccak sponge controller and its producer/consumer.
interface keccak_sponge_ctrl_if #(
    parameter int LEN_W = 11
);
    logic             in_valid;
    logic             in_last;
    logic [LEN_W-1:0] in_len;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, in_last, in_len, out_ready,
        input  in_ready, out_valid
    );

    modport slave (
        input  in_valid, in_last, in_len, out_ready,
        output in_ready, out_valid
    );
endinterface

// File: rtl/keccak_sponge_ctrl.sv
// Keccak sponge sequencer: buffers rate blocks, absorbs/permutes them, then squeezes sq_blocks outputs.
// Optional `SPONGE_ABORT_EN adds an abort input that returns any busy state to IDLE.
module keccak_sponge_ctrl #(
    parameter int BLOCK_W = 1088,
    parameter int DEPTH   = 8,
    parameter int ROUNDS  = 24,
    parameter int LEN_W   = 11,
    parameter int SQ_W    = 8,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SQ_W-1:0]  sq_blocks,
    keccak_sponge_ctrl_if.slave bus,
    output logic [AW-1:0]    wr_addr,
    output logic             wren,
    output logic [AW-1:0]    rd_addr,
    output logic [LEN_W-1:0] last_len,
    output logic             last_sel,
    output logic [1:0]       state_sel,
    output logic [RW-1:0]    round_idx,
    output logic             aclr,
    output logic             busy,
    output logic             full,
    output logic             err
`ifdef SPONGE_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [2:0] {IDLE, FILL, ABSORB, PERMUTE, SQUEEZE} state_t;

    localparam logic [1:0] SEL_PERM = 2'd0;
    localparam logic [1:0] SEL_ABS  = 2'd1;
    localparam logic [1:0] SEL_HOLD = 2'd2;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_addr_q, rd_addr_q;
    logic [CW-1:0]     block_cnt_q;
    logic [LEN_W-1:0]  last_len_q;
    logic [RW-1:0]     rnd_q;
    logic [SQ_W-1:0]   sq_lat_q, sq_done_q;
    logic              err_q, aclr_q;

    logic              go, accept, hs, abort_hit;
    logic              rnd_last, more_blk, adv_blk, last_out, len_bad;
    logic              in_rdy, o_vld;
    logic [SQ_W:0]     sq_eff;
    logic [CW-1:0]     rd_next;

    assign full     = (block_cnt_q == CW'(DEPTH));
    assign rd_next  = CW'(rd_addr_q) + CW'(1);
    assign more_blk = (rd_next < block_cnt_q);
    assign rnd_last = (rnd_q == RW'(ROUNDS - 1));
    assign len_bad  = (bus.in_len > LEN_W'(BLOCK_W));
    // A request of zero output blocks still yields one block.
    assign sq_eff   = (sq_lat_q == '0) ? (SQ_W+1)'(1) : {1'b0, sq_lat_q};
    assign last_out = (({1'b0, sq_done_q} + (SQ_W+1)'(1)) >= sq_eff);

    always_comb begin
        state_d   = state_q;
        in_rdy    = 1'b0;
        o_vld     = 1'b0;
        state_sel = SEL_HOLD;
        last_sel  = 1'b0;
        go        = 1'b0;
        accept    = 1'b0;
        hs        = 1'b0;
        adv_blk   = 1'b0;
        abort_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    go      = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                in_rdy = ~full;
                if (bus.in_valid && in_rdy) begin
                    accept = 1'b1;
                    if (bus.in_last)
                        state_d = len_bad ? IDLE : ABSORB;
                end else if (full) begin
                    state_d = IDLE;
                end
            end
            ABSORB: begin
                state_sel = SEL_ABS;
                last_sel  = (rd_next == block_cnt_q);
                state_d   = PERMUTE;
            end
            PERMUTE: begin
                state_sel = SEL_PERM;
                if (rnd_last) begin
                    // Squeeze-phase permutes always have at least one block delivered.
                    if (sq_done_q == '0 && more_blk) begin
                        adv_blk = 1'b1;
                        state_d = ABSORB;
                    end else begin
                        state_d = SQUEEZE;
                    end
                end
            end
            SQUEEZE: begin
                o_vld = 1'b1;
                if (bus.out_ready) begin
                    hs      = 1'b1;
                    state_d = last_out ? IDLE : PERMUTE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef SPONGE_ABORT_EN
        if (abort && state_q != IDLE) begin
            abort_hit = 1'b1;
            state_d   = IDLE;
            in_rdy    = 1'b0;
            o_vld     = 1'b0;
            accept    = 1'b0;
            hs        = 1'b0;
            adv_blk   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            block_cnt_q <= '0;
            last_len_q  <= '0;
            rnd_q       <= '0;
            sq_lat_q    <= '0;
            sq_done_q   <= '0;
            err_q       <= 1'b0;
            aclr_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            aclr_q  <= go | abort_hit;
            if (go) begin
                wr_addr_q   <= '0;
                rd_addr_q   <= '0;
                block_cnt_q <= '0;
                last_len_q  <= '0;
                rnd_q       <= '0;
                sq_lat_q    <= sq_blocks;
                sq_done_q   <= '0;
                err_q       <= 1'b0;
            end
            if (accept) begin
                wr_addr_q   <= wr_addr_q + AW'(1);
                block_cnt_q <= block_cnt_q + CW'(1);
                if (bus.in_last) begin
                    if (len_bad) err_q <= 1'b1;
                    else         last_len_q <= bus.in_len;
                end else if (block_cnt_q == CW'(DEPTH - 1)) begin
                    // Overflow is flagged with the write that fills the buffer.
                    err_q <= 1'b1;
                end
            end
            if (abort_hit)
                rnd_q <= '0;
            else if (state_q == PERMUTE)
                rnd_q <= rnd_last ? '0 : rnd_q + RW'(1);
            if (adv_blk)
                rd_addr_q <= rd_addr_q + AW'(1);
            if (hs)
                sq_done_q <= sq_done_q + SQ_W'(1);
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = o_vld;
    assign wren          = accept;
    assign wr_addr       = wr_addr_q;
    assign rd_addr       = rd_addr_q;
    assign last_len      = last_len_q;
    assign round_idx     = rnd_q;
    assign aclr          = aclr_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Directed bench for keccak_sponge_ctrl at default parameters (rate 1088, 8 blocks, 24 rounds).
module tb_keccak_sponge_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  sq_blocks;
    logic [2:0]  wr_addr, rd_addr;
    logic        wren, last_sel, aclr, busy, full, err;
    logic [10:0] last_len;
    logic [1:0]  state_sel;
    logic [4:0]  round_idx;
`ifdef SPONGE_ABORT_EN
    logic        abort;
`endif

    int total = 0;
    int bad   = 0;

    keccak_sponge_ctrl_if #(.LEN_W(11)) bus ();

    keccak_sponge_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .sq_blocks (sq_blocks),
        .bus       (bus),
        .wr_addr   (wr_addr),
        .wren      (wren),
        .rd_addr   (rd_addr),
        .last_len  (last_len),
        .last_sel  (last_sel),
        .state_sel (state_sel),
        .round_idx (round_idx),
        .aclr      (aclr),
        .busy      (busy),
        .full      (full),
        .err       (err)
`ifdef SPONGE_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [7:0] sq);
        start     = 1'b1;
        sq_blocks = sq;
        step(1);
        start     = 1'b0;
    endtask

    task automatic send(input logic last, input logic [10:0] len);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.in_len   = len;
        step(1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin : main
        int hs_cnt;
        int perm_ok;
        int ov_seen;
        reset         = 1'b1;
        start         = 1'b0;
        sq_blocks     = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_len    = 11'd0;
        bus.out_ready = 1'b0;
`ifdef SPONGE_ABORT_EN
        abort         = 1'b0;
`endif
        step(2);
        chk("rst_state_sel", 32'(state_sel), 32'd2);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_aclr",      32'(aclr),      32'd0);
        chk("rst_err",       32'(err),       32'd0);
        reset = 1'b0;
        step(1);

        // One block, in_len 0, one output block.
        do_start(8'd1);
        chk("a_aclr_first", 32'(aclr), 32'd1);
        chk("a_in_ready",   32'(bus.in_ready), 32'd1);
        chk("a_busy",       32'(busy), 32'd1);
        bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_len = 11'd0;
        #1;
        chk("a_wren", 32'(wren), 32'd1);
        step(1);                                  // now F+1
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("a_absorb_sel", 32'(state_sel), 32'd1);
        chk("a_rd_addr",    32'(rd_addr),   32'd0);
        chk("a_last_sel",   32'(last_sel),  32'd1);
        chk("a_aclr_once",  32'(aclr),      32'd0);
        step(1);
        chk("a_round0",     32'(round_idx), 32'd0);
        step(23);                                 // F+25
        chk("a_round23",    32'(round_idx), 32'd23);
        chk("a_ov_early",   32'(bus.out_valid), 32'd0);
        step(1);                                  // F+26
        chk("a_ov_f26",     32'(bus.out_valid), 32'd1);
        chk("a_hold_sel",   32'(state_sel), 32'd2);
        step(1);                                  // F+27
        chk("a_ov_held",    32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step(1);                                  // F+28
        bus.out_ready = 1'b0;
        chk("a_busy_done",  32'(busy), 32'd0);

        // Three blocks, last in_len 500.
        do_start(8'd1);
        send(1'b0, 11'd0);
        chk("b_aclr_second", 32'(aclr), 32'd0);
        send(1'b0, 11'd0);
        bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_len = 11'd500;
        #1;
        chk("b_wr_addr2", 32'(wr_addr), 32'd2);
        step(1);                                  // F+1
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("b_rd0",       32'(rd_addr),  32'd0);
        chk("b_ls0",       32'(last_sel), 32'd0);
        chk("b_last_len",  32'(last_len), 32'd500);
        step(25);                                 // F+26
        chk("b_abs1_sel",  32'(state_sel), 32'd1);
        chk("b_rd1",       32'(rd_addr),  32'd1);
        chk("b_ls1",       32'(last_sel), 32'd0);
        step(25);                                 // F+51
        chk("b_rd2",       32'(rd_addr),  32'd2);
        chk("b_ls2",       32'(last_sel), 32'd1);
        step(24);                                 // F+75
        chk("b_ov_f75",    32'(bus.out_valid), 32'd0);
        step(1);                                  // F+76
        chk("b_ov_f76",    32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        chk("b_busy_done", 32'(busy), 32'd0);

        // One block, three output blocks, consumer stalls 5 cycles each.
        do_start(8'd3);
        send(1'b1, 11'd64);
        step(25);                                 // F+26
        hs_cnt = 0; perm_ok = 0;
        for (int k = 0; k < 3; k++) begin
            step(5);
            chk("c_ov_stall", 32'(bus.out_valid), 32'd1);
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) hs_cnt++;
            step(1);
            bus.out_ready = 1'b0;
            if (k < 2) begin
                for (int i = 0; i < 24; i++) begin
                    if (state_sel == 2'd0 && round_idx == 5'(i)) perm_ok++;
                    step(1);
                end
                chk("c_ov_next", 32'(bus.out_valid), 32'd1);
            end
        end
        chk("c_busy_done", 32'(busy), 32'd0);
        chk("c_handshakes", 32'(hs_cnt), 32'd3);
        chk("c_perm_rounds", 32'(perm_ok), 32'd48);

        // sq_blocks 0 behaves as 1; in_len = BLOCK_W is legal.
        do_start(8'd0);
        send(1'b1, 11'd1088);
        chk("z_err", 32'(err), 32'd0);
        chk("z_last_len", 32'(last_len), 32'd1088);
        step(25);
        chk("z_ov", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        chk("z_busy_done", 32'(busy), 32'd0);

        // Overflow: eight blocks without in_last.
        do_start(8'd1);
        bus.in_valid = 1'b1; bus.in_last = 1'b0; bus.in_len = 11'd0;
        step(7);
        chk("d_ready_7", 32'(bus.in_ready), 32'd1);
        chk("d_full_7",  32'(full), 32'd0);
        step(1);                                  // W+1
        chk("d_full",     32'(full), 32'd1);
        chk("d_in_ready", 32'(bus.in_ready), 32'd0);
        chk("d_wren_off", 32'(wren), 32'd0);
        chk("d_err",      32'(err), 32'd1);
        step(1);                                  // W+2
        bus.in_valid = 1'b0;
        chk("d_idle",     32'(busy), 32'd0);
        chk("d_err_held", 32'(err), 32'd1);
        do_start(8'd1);
        chk("d_err_clr",  32'(err), 32'd0);
        chk("d_full_clr", 32'(full), 32'd0);

        // start ignored mid-run, then reset mid-PERMUTE.
        send(1'b1, 11'd7);                        // F+1
        chk("r_last_len", 32'(last_len), 32'd7);
        step(4);                                  // F+5, round 3
        start = 1'b1; sq_blocks = 8'd9;
        step(1);
        start = 1'b0;
        chk("r_start_ign", 32'(round_idx), 32'd4);
        step(6);                                  // round 10
        chk("r_round10", 32'(round_idx), 32'd10);
        reset = 1'b1;
        #1;
        chk("r_busy",      32'(busy), 32'd0);
        chk("r_state_sel", 32'(state_sel), 32'd2);
        chk("r_round_idx", 32'(round_idx), 32'd0);
        chk("r_last_len0", 32'(last_len), 32'd0);
        chk("r_rd_addr",   32'(rd_addr), 32'd0);
        step(1);
        reset = 1'b0;
        step(1);

        // Oversized final block.
        do_start(8'd1);
        send(1'b1, 11'd1089);
        chk("e_err",  32'(err), 32'd1);
        chk("e_busy", 32'(busy), 32'd0);
        chk("e_sel",  32'(state_sel), 32'd2);
        step(2);
        chk("e_no_absorb", 32'(state_sel), 32'd2);

`ifdef SPONGE_ABORT_EN
        // Abort in round 10 of the second block.
        do_start(8'd1);
        send(1'b0, 11'd0);
        send(1'b1, 11'd8);                        // F+1
        step(36);                                 // F+37
        chk("x_round10", 32'(round_idx), 32'd10);
        chk("x_block1",  32'(rd_addr), 32'd1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("x_idle",   32'(busy), 32'd0);
        chk("x_aclr",   32'(aclr), 32'd1);
        chk("x_err",    32'(err), 32'd0);
        ov_seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 1) chk("x_aclr_once", 32'(aclr), 32'd0);
            if (bus.out_valid) ov_seen++;
            step(1);
        end
        chk("x_no_ov", 32'(ov_seen), 32'd0);
`else
        ov_seen = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
